// File: rtl/gcd_pkg.sv
// ============================================================================
// Module   : gcd_pkg
// Brief    : Shared FSM encoding and sizing helper for the Stein GCD block.
// Revision : 1.0
// ============================================================================
`default_nettype none

package gcd_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Wide enough for the shift exponent and the worst-case 2*WIDTH+1 step count.
    function automatic int cnt_width(input int width);
        return $clog2(2 * width + 2);
    endfunction

endpackage

`default_nettype wire

// File: rtl/gcd_stein_step.sv
// ============================================================================
// Module   : gcd_stein_step
// Brief    : One combinational binary-GCD step (zero check, halving, subtract).
// Revision : 1.0
// ============================================================================
`default_nettype none

module gcd_stein_step #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 7
) (
    input  logic [WIDTH-1:0] ra,
    input  logic [WIDTH-1:0] rb,
    input  logic [CNT_W-1:0] k,
    output logic [WIDTH-1:0] ra_nxt,
    output logic [WIDTH-1:0] rb_nxt,
    output logic [CNT_W-1:0] k_nxt,
    output logic             finish,
    output logic [WIDTH-1:0] result
);

    always_comb begin
        ra_nxt = ra;
        rb_nxt = rb;
        k_nxt  = k;
        finish = 1'b0;
        result = '0;
        if (ra == '0) begin
            finish = 1'b1;
            result = rb << k;
        end else if (rb == '0) begin
            finish = 1'b1;
            result = ra << k;
        end else if (!ra[0] && !rb[0]) begin
            ra_nxt = ra >> 1;
            rb_nxt = rb >> 1;
            k_nxt  = k + CNT_W'(1);
        end else if (!ra[0]) begin
            ra_nxt = ra >> 1;
        end else if (!rb[0]) begin
            rb_nxt = rb >> 1;
        end else if (ra >= rb) begin
            // Difference of two odd values is even, so halving it loses nothing.
            ra_nxt = (ra - rb) >> 1;
        end else begin
            rb_nxt = (rb - ra) >> 1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/gcd_stein.sv
// ============================================================================
// Module   : gcd_stein
// Brief    : Iterative binary GCD with ap_ctrl_hs handshake and cycle counter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module gcd_stein
    import gcd_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = cnt_width(WIDTH)
) (
    input  logic             ap_clk,
    input  logic             ap_rst_n,
    input  logic             ap_start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ap_ready,
    output logic             ap_idle,
    output logic             ap_done,
    output logic [WIDTH-1:0] ap_return,
    output logic [CNT_W-1:0] ap_cycles
);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic [CNT_W-1:0] k;
    logic [CNT_W-1:0] cnt;

    logic [WIDTH-1:0] step_ra;
    logic [WIDTH-1:0] step_rb;
    logic [CNT_W-1:0] step_k;
    logic             step_finish;
    logic [WIDTH-1:0] step_result;

    gcd_stein_step #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_step (
        .ra     (ra),
        .rb     (rb),
        .k      (k),
        .ra_nxt (step_ra),
        .rb_nxt (step_rb),
        .k_nxt  (step_k),
        .finish (step_finish),
        .result (step_result)
    );

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ap_ready  = 1'b0;
        case (state)
            IDLE: begin
                if (ap_start) begin
                    ap_ready  = 1'b1;
                    state_nxt = CALC;
                end
            end
            CALC: begin
                if (step_finish) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            ra        <= '0;
            rb        <= '0;
            k         <= '0;
            cnt       <= '0;
            ap_return <= '0;
            ap_cycles <= '0;
            ap_done   <= 1'b0;
            ap_idle   <= 1'b1;
        end else begin
            ap_done <= (state_nxt == DONE);
            ap_idle <= (state_nxt == IDLE);
            case (state)
                IDLE: begin
                    if (ap_start) begin
                        ra  <= a;
                        rb  <= b;
                        k   <= '0;
                        cnt <= '0;
                    end
                end
                CALC: begin
                    cnt <= cnt + CNT_W'(1);
                    ra  <= step_ra;
                    rb  <= step_rb;
                    k   <= step_k;
                    // The terminating zero-check cycle is itself counted.
                    if (step_finish) begin
                        ap_return <= step_result;
                        ap_cycles <= cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_gcd_stein.sv
// ============================================================================
// Module   : tb_gcd_stein
// Brief    : Scoreboard bench for gcd_stein at WIDTH=32 and WIDTH=8.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_gcd_stein;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start32, start8;
    logic [31:0] a32, b32;
    logic [7:0]  a8, b8;
    logic        ready32, idle32, done32, ready8, idle8, done8;
    logic [31:0] ret32;
    logic [7:0]  ret8;
    logic [6:0]  cyc32;
    logic [4:0]  cyc8;

    gcd_stein #(.WIDTH(32)) dut32 (
        .ap_clk(clk), .ap_rst_n(rst_n), .ap_start(start32), .a(a32), .b(b32),
        .ap_ready(ready32), .ap_idle(idle32), .ap_done(done32),
        .ap_return(ret32), .ap_cycles(cyc32)
    );

    gcd_stein #(.WIDTH(8)) dut8 (
        .ap_clk(clk), .ap_rst_n(rst_n), .ap_start(start8), .a(a8), .b(b8),
        .ap_ready(ready8), .ap_idle(idle8), .ap_done(done8),
        .ap_return(ret8), .ap_cycles(cyc8)
    );

    typedef struct {
        logic [31:0] res;
        int          ec;
        int          cap;
    } exp_t;

    exp_t q32[$];
    exp_t q8[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   done_n32 = 0, done_n8 = 0;
    int   issued32 = 0, issued8 = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Euclid by remainder: independent of the hardware's binary method.
    function automatic logic [31:0] ref_gcd(input logic [31:0] x, input logic [31:0] y);
        logic [31:0] t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // Exact CALC counts stated for specific operand pairs; -1 where only the bound applies.
    function automatic int exact_cycles(input logic [31:0] x, input logic [31:0] y);
        if (x == 0 || y == 0) return 1;
        if (x == 24 && y == 56) return 8;
        return -1;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (ready32) q32.push_back('{res: ref_gcd(a32, b32), ec: exact_cycles(a32, b32), cap: cyc});
        if (ready8)  q8.push_back('{res: ref_gcd({24'd0, a8}, {24'd0, b8}),
                                    ec: exact_cycles({24'd0, a8}, {24'd0, b8}), cap: cyc});
    end

    always @(negedge clk) begin
        exp_t e;
        if (done32) begin
            done_n32++;
            if (q32.size() == 0) begin
                chk("done32_unexpected", 1, 0);
            end else begin
                e = q32.pop_front();
                chk("ret32", {32'd0, ret32}, {32'd0, e.res});
                chk("cyc32_bound", {63'd0, (cyc32 >= 1 && cyc32 <= 65)}, 1);
                chk("idle32_in_done", {63'd0, idle32}, 0);
                chk("ready32_in_done", {63'd0, ready32}, 0);
                if (e.ec >= 0) begin
                    chk("cyc32_exact", {57'd0, cyc32}, 64'(e.ec));
                    chk("lat32", 64'(cyc - e.cap), 64'(e.ec + 1));
                end
            end
        end
        if (done8) begin
            done_n8++;
            if (q8.size() == 0) begin
                chk("done8_unexpected", 1, 0);
            end else begin
                e = q8.pop_front();
                chk("ret8", {56'd0, ret8}, {32'd0, e.res});
                chk("cyc8_bound", {63'd0, (cyc8 >= 1 && cyc8 <= 17)}, 1);
                chk("idle8_in_done", {63'd0, idle8}, 0);
                if (e.ec >= 0) chk("cyc8_exact", {59'd0, cyc8}, 64'(e.ec));
            end
        end
    end

    task automatic wait_done32(input int n);
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #2;
            if (done_n32 >= n) return;
        end
        chk("timeout32", 64'(done_n32), 64'(n));
    endtask

    task automatic wait_done8(input int n);
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #2;
            if (done_n8 >= n) return;
        end
        chk("timeout8", 64'(done_n8), 64'(n));
    endtask

    // Called in IDLE just after a clock edge; scrambles operands during CALC.
    task automatic op32(input logic [31:0] x, input logic [31:0] y);
        a32 = x; b32 = y; start32 = 1'b1; issued32++;
        #1 chk("ready32", {63'd0, ready32}, 1);
        @(posedge clk); #2;
        start32 = 1'b0; a32 = $urandom; b32 = $urandom;
        wait_done32(done_n32 + 1);
    endtask

    task automatic op8(input logic [7:0] x, input logic [7:0] y);
        a8 = x; b8 = y; start8 = 1'b1; issued8++;
        @(posedge clk); #2;
        start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
        wait_done8(done_n8 + 1);
    endtask

    initial begin
        logic [31:0] m;
        int          held;
        rst_n = 1'b0; start32 = 1'b0; start8 = 1'b0;
        a32 = '0; b32 = '0; a8 = '0; b8 = '0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_idle32", {63'd0, idle32}, 1);
        chk("rst_done32", {63'd0, done32}, 0);
        chk("rst_ret32", {32'd0, ret32}, 0);
        chk("rst_cyc32", {57'd0, cyc32}, 0);
        chk("rst_ready32", {63'd0, ready32}, 0);
        chk("rst_idle8", {63'd0, idle8}, 1);
        rst_n = 1'b1;
        @(posedge clk); #2;

        // Back-to-back with start held high.
        a32 = 32'd24; b32 = 32'd56; start32 = 1'b1; issued32 += 2;
        #1 chk("b2b_ready32", {63'd0, ready32}, 1);
        wait_done32(2);
        start32 = 1'b0;
        @(posedge clk); #2;

        op32(0, 0);
        op32(0, 17);
        op32(17, 0);
        op32(32'h8000_0000, 32'h4000_0000);
        op32(32'hFFFF_FFFF, 32'hFFFF_FFFE);

        // Reset while the third CALC step is in progress.
        a32 = 32'd1071; b32 = 32'd462; start32 = 1'b1;
        @(posedge clk); #2;
        start32 = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        @(posedge clk);
        q32.delete();
        #2;
        chk("abort_idle32", {63'd0, idle32}, 1);
        chk("abort_ret32", {32'd0, ret32}, 0);
        chk("abort_cyc32", {57'd0, cyc32}, 0);
        chk("abort_done32", {63'd0, done32}, 0);
        rst_n = 1'b1;
        held = done_n32;
        repeat (10) @(posedge clk);
        #2 chk("abort_no_done32", 64'(done_n32), 64'(held));
        op32(1071, 462);

        // Single start pulse: no further operations while start stays low.
        op32(48, 18);
        held = done_n32;
        repeat (20) @(posedge clk);
        #2;
        chk("no_rerun32", 64'(done_n32), 64'(held));
        chk("idle_hold32", {63'd0, idle32}, 1);

        for (int i = 0; i < 12; i++) op32($urandom, $urandom);
        for (int i = 0; i < 12; i++) begin
            m = $urandom_range(1, 4096);
            op32(32'($urandom_range(0, 65535)) * m, 32'($urandom_range(0, 65535)) * m);
        end

        op8(255, 1);
        op8(240, 180);
        op8(0, 255);
        for (int i = 0; i < 30; i++) op8(8'($urandom), 8'($urandom));

        repeat (5) @(posedge clk);
        #2;
        chk("count32", 64'(done_n32), 64'(issued32));
        chk("count8", 64'(done_n8), 64'(issued8));
        chk("q32_empty", 64'(q32.size()), 0);
        chk("q8_empty", 64'(q8.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/gcd_stein.md
Name: gcd_stein

Overview:
- Parametrised successor to the fixed 32-bit `gcd` block.
- Computes GCD(a,b) with the binary (Stein) algorithm: one shift/subtract step per cycle, no divider.
- Uses the full ap_ctrl_hs handshake: start/ready/done/idle.
- Adds a per-operation cycle counter for performance characterisation.
- Instantiated wherever the HLS-style datapath needs a gcd; drop-in for the 32-bit version when WIDTH=32.

Parameters:
- WIDTH, 32, operand and result width in bits.
- CNT_W, $clog2(2*WIDTH+2), width of the shift exponent and the cycle counter.

Ports:
- ap_clk  in  1  clock; all state updates on the rising edge.
- ap_rst_n  in  1  reset; synchronous, active-low.
- ap_start  in  1  request; sampled only in IDLE.
- a  in  WIDTH  operand A; captured when ap_ready=1.
- b  in  WIDTH  operand B; captured when ap_ready=1.
- ap_ready  out  1  combinational, = (state==IDLE) & ap_start; operands consumed this cycle.
- ap_idle  out  1  registered, 1 in IDLE.
- ap_done  out  1  registered, one-cycle pulse in DONE.
- ap_return  out  WIDTH  GCD result; updated on entry to DONE, held until the next DONE.
- ap_cycles  out  CNT_W  number of CALC cycles used by the last operation; updated together with ap_return.

Behaviour:
- Reset (ap_rst_n=0 at a clock edge) from any state, including mid-CALC:
  - state=IDLE; ap_return=0, ap_cycles=0, ap_done=0, ap_idle=1.
  - Internal ra, rb, k and cnt cleared.
  - No done pulse is produced for an aborted operation.
- IDLE:
  - ap_start=1 makes ap_ready=1 in the same cycle.
  - At that edge: ra<=a, rb<=b, k<=0, cnt<=0; go to CALC.
  - ap_start=0: stay in IDLE.
- CALC: one step per cycle; cnt increments every CALC cycle. Steps in priority order:
  - ra==0: result=rb<<k; go to DONE.
  - rb==0: result=ra<<k; go to DONE.
  - Both even: ra>>=1, rb>>=1, k++.
  - ra even: ra>>=1.
  - rb even: rb>>=1.
  - Both odd, ra>=rb: ra<=(ra-rb)>>1.
  - Both odd, ra<rb: rb<=(rb-ra)>>1.
- Arithmetic rules:
  - Subtraction is unsigned WIDTH-bit and never underflows because of the compare.
  - The final shift rb<<k cannot overflow: the result is at most max(a,b).
- Latency bound: CALC takes at most 2*WIDTH+1 cycles. ap_cycles records the exact count, including the terminating zero-check cycle.
- DONE (one cycle):
  - ap_done=1; ap_return and ap_cycles valid from this cycle onward.
  - Next state is IDLE unconditionally.
  - ap_start is ignored in DONE.
- Back-to-back operation: with ap_start held at 1, the sequence repeats IDLE(ready)→CALC…→DONE→IDLE(ready).
  - Operands are re-sampled at each IDLE.
  - One idle cycle sits between operations.
- Zero operands:
  - gcd(0,0)=0 and gcd(x,0)=gcd(0,x)=x.
  - Each takes exactly 1 CALC cycle.
- ap_idle=0 in CALC and DONE.
- Operand changes during CALC have no effect.

Decomposition:
- Package gcd_pkg holds:
  - state enum {IDLE, CALC, DONE} and its encoding.
  - Helper function for CNT_W.
- Sub-module gcd_stein_step holds the purely combinational step:
  - Inputs: ra, rb, k.
  - Outputs: next ra, rb, k, finish flag and result.
- The top module keeps the FSM, registers and counters.

Test Plan:
- WIDTH=32, a=24, b=56, ap_start held at 1 after reset release:
  - ap_ready pulses in the first IDLE cycle.
  - ap_done one cycle after 8 CALC cycles, with ap_return=8 and ap_cycles=8.
  - Then repeats.
- Zero cases:
  - (0,0) → ap_return=0, ap_cycles=1.
  - (0,17) → 17.
  - (17,0) → 17.
- Powers of two and coprime operands:
  - (0x80000000, 0x40000000) → 0x40000000.
  - (0xFFFFFFFF, 0xFFFFFFFE) → 1, with ap_cycles ≤ 65.
- Reset mid-operation:
  - Start (1071,462), assert ap_rst_n=0 at CALC cycle 3.
  - Required: next cycle ap_idle=1, ap_return=0, no ap_done pulse.
  - Restart → 21.
- Handshake discipline:
  - Pulse ap_start for one cycle, then change a and b during CALC.
  - Result reflects the captured (48,18) → 6.
  - No second operation runs while ap_start stays 0.
- WIDTH=8 instance:
  - (255,1) → 1.
  - (240,180) → 60.
  - (0,255) → 255.
  - ap_cycles never exceeds 17.
